// File: rtl/signal_capture_if.sv
// signal_capture_if : sample stream, trigger control and readout bundle for signal_capture (rev 1.0)
`default_nettype none

interface signal_capture_if #(
   parameter int DATA_W     = 12,
   parameter int DEPTH_LOG2 = 8
);
   logic                  sample_en;
   logic [DATA_W-1:0]     sample_in;
   logic                  arm;
   logic                  force_trig;
   logic [DATA_W-1:0]     trig_level;
   logic                  trig_slope;
   logic [DEPTH_LOG2-1:0] rd_addr;
   logic [DATA_W-1:0]     rd_data;
   logic                  busy;
   logic                  armed;
   logic                  done;

   modport master (
      output sample_en, sample_in, arm, force_trig, trig_level, trig_slope, rd_addr,
      input  rd_data, busy, armed, done
   );

   modport slave (
      input  sample_en, sample_in, arm, force_trig, trig_level, trig_slope, rd_addr,
      output rd_data, busy, armed, done
   );
endinterface

`default_nettype wire

// File: rtl/signal_capture.sv
// signal_capture : triggered circular capture buffer with pre-trigger history and random-access readout (rev 1.0)
`default_nettype none

module signal_capture #(
   parameter int DATA_W     = 12,
   parameter int DEPTH_LOG2 = 8,
   parameter int PRETRIG    = 32
) (
   input  logic            clk,
   input  logic            reset,
   signal_capture_if.slave bus
);

   localparam int                    c_depth    = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2-1:0] c_pretrig  = DEPTH_LOG2'(PRETRIG);
   localparam logic [DEPTH_LOG2-1:0] c_pre_last = DEPTH_LOG2'(PRETRIG - 1);
   localparam logic [DEPTH_LOG2-1:0] c_post_cnt = DEPTH_LOG2'(c_depth - PRETRIG - 1);
   localparam logic [DEPTH_LOG2-1:0] c_one      = DEPTH_LOG2'(1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_PRE   = 3'd1,
      S_ARMED = 3'd2,
      S_POST  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [DEPTH_LOG2-1:0] r_wp;
   logic [DEPTH_LOG2-1:0] r_cnt;
   logic [DEPTH_LOG2-1:0] r_start;
   logic [DATA_W-1:0]     r_prev;
   logic                  r_force_pend;
   logic [DATA_W-1:0]     r_rd_data;
   logic [DATA_W-1:0]     mem [c_depth];

   logic                  w_capturing;
   logic                  w_accept;
   logic                  w_arm_go;
   logic                  w_rise;
   logic                  w_fall;
   logic                  w_trig;
   logic [DEPTH_LOG2-1:0] w_rd_ptr;

   assign w_capturing = (r_state == S_PRE) || (r_state == S_ARMED) || (r_state == S_POST);
   assign w_accept    = bus.sample_en && w_capturing;
   assign w_arm_go    = bus.arm && ((r_state == S_IDLE) || (r_state == S_DONE));

   assign w_rise = ($signed(r_prev) < $signed(bus.trig_level)) &&
                   ($signed(bus.sample_in) >= $signed(bus.trig_level));
   assign w_fall = ($signed(r_prev) > $signed(bus.trig_level)) &&
                   ($signed(bus.sample_in) <= $signed(bus.trig_level));

   // A force pulse coincident with an accepted sample triggers on that sample.
   assign w_trig = w_accept && (r_state == S_ARMED) &&
                   ((bus.trig_slope ? w_fall : w_rise) || r_force_pend || bus.force_trig);

   assign w_rd_ptr = r_start + bus.rd_addr;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (bus.arm) w_state_nxt = S_PRE;
         S_PRE:   if (w_accept && (r_cnt == c_pre_last)) w_state_nxt = S_ARMED;
         S_ARMED: if (w_trig) w_state_nxt = (c_post_cnt == '0) ? S_DONE : S_POST;
         S_POST:  if (w_accept && (r_cnt == c_one)) w_state_nxt = S_DONE;
         S_DONE:  if (bus.arm) w_state_nxt = S_PRE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wp         <= '0;
         r_cnt        <= '0;
         r_start      <= '0;
         r_prev       <= '0;
         r_force_pend <= 1'b0;
         r_rd_data    <= '0;
      end else begin
         if (w_arm_go) begin
            r_wp         <= '0;
            r_cnt        <= '0;
            r_force_pend <= 1'b0;
         end else begin
            if (w_accept) begin
               r_wp   <= r_wp + c_one;
               r_prev <= bus.sample_in;
            end
            if (w_trig) begin
               r_start      <= r_wp - c_pretrig;
               r_cnt        <= c_post_cnt;
               r_force_pend <= 1'b0;
            end else if (w_accept && (r_state == S_PRE)) begin
               r_cnt <= r_cnt + c_one;
            end else if (w_accept && (r_state == S_POST)) begin
               r_cnt <= r_cnt - c_one;
            end else if ((r_state == S_ARMED) && bus.force_trig) begin
               r_force_pend <= 1'b1;
            end
         end
         r_rd_data <= mem[w_rd_ptr];
      end
   end

   // Capture RAM carries no reset so it maps onto block memory.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         mem[r_wp] <= bus.sample_in;
      end
   end

   assign bus.rd_data = r_rd_data;
   assign bus.busy    = w_capturing;
   assign bus.armed   = (r_state == S_ARMED);
   assign bus.done    = (r_state == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_signal_capture.sv
// tb_signal_capture : randomized self-checking bench for signal_capture against a sample-history model (rev 1.0)
`default_nettype none

module tb_signal_capture;

   localparam int DATA_W     = 12;
   localparam int DEPTH_LOG2 = 8;
   localparam int DEPTH      = 1 << DEPTH_LOG2;
   localparam int PRETRIG    = 32;

   localparam int P_IDLE  = 0;
   localparam int P_PRE   = 1;
   localparam int P_ARMED = 2;
   localparam int P_POST  = 3;
   localparam int P_DONE  = 4;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   signal_capture_if #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) bus ();

   signal_capture #(
      .DATA_W     (DATA_W),
      .DEPTH_LOG2 (DEPTH_LOG2),
      .PRETRIG    (PRETRIG)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Model: every sample accepted since the last arm, plus the index of the trigger sample.
   bit m_active = 1'b0;
   int m_hist[$];
   int m_trig   = -1;
   bit m_fp     = 1'b0;
   int m_level  = 0;
   bit m_slope  = 1'b0;

   task automatic check(string tag, int obs, int exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int to_s(int v);
      logic [DATA_W-1:0] t;
      t = DATA_W'(v);
      return int'($signed(t));
   endfunction

   function automatic int phase();
      if (!m_active) return P_IDLE;
      if (m_trig < 0) return (m_hist.size() < PRETRIG) ? P_PRE : P_ARMED;
      return (m_hist.size() >= m_trig + DEPTH - PRETRIG) ? P_DONE : P_POST;
   endfunction

   function automatic int exp_status();
      int ph;
      ph = phase();
      return ((ph == P_PRE || ph == P_ARMED || ph == P_POST) ? 4 : 0) +
             ((ph == P_ARMED) ? 2 : 0) + ((ph == P_DONE) ? 1 : 0);
   endfunction

   task automatic model_step(bit se, int s, bit a, bit ft);
      int  ph;
      int  prev;
      bit  hit;
      ph = phase();
      if (ph == P_IDLE || ph == P_DONE) begin
         if (a) begin
            m_active = 1'b1;
            m_hist.delete();
            m_trig = -1;
            m_fp   = 1'b0;
         end
      end else if (se) begin
         if (ph == P_ARMED) begin
            prev = m_hist[$];
            hit  = m_slope ? (prev > m_level && s <= m_level)
                           : (prev < m_level && s >= m_level);
            if (hit || m_fp || ft) begin
               m_trig = m_hist.size();
               m_fp   = 1'b0;
            end
         end
         m_hist.push_back(s);
      end else if (ph == P_ARMED && ft) begin
         m_fp = 1'b1;
      end
   endtask

   task automatic set_trigger(int level, bit slope);
      m_level        = level;
      m_slope        = slope;
      bus.trig_level = DATA_W'(level);
      bus.trig_slope = slope;
   endtask

   task automatic step(bit se, int s, bit a, bit ft, string tag);
      bus.sample_en  = se;
      bus.sample_in  = DATA_W'(s);
      bus.arm        = a;
      bus.force_trig = ft;
      model_step(se, to_s(s), a, ft);
      @(posedge clk);
      #1;
      bus.sample_en  = 1'b0;
      bus.arm        = 1'b0;
      bus.force_trig = 1'b0;
      check(tag, int'({bus.busy, bus.armed, bus.done}), exp_status());
   endtask

   task automatic read_at(int a, output int v);
      bus.rd_addr = DEPTH_LOG2'(a);
      @(posedge clk);
      #1;
      v = to_s(int'(bus.rd_data));
   endtask

   task automatic read_window(string tag);
      int v;
      for (int a = 0; a < DEPTH; a++) begin
         read_at(a, v);
         check(tag, v, m_hist[m_trig - PRETRIG + a]);
      end
   endtask

   int v;
   int n;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bus.sample_en  = 1'b0;
      bus.sample_in  = '0;
      bus.arm        = 1'b0;
      bus.force_trig = 1'b0;
      bus.trig_level = '0;
      bus.trig_slope = 1'b0;
      bus.rd_addr    = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_status", int'({bus.busy, bus.armed, bus.done}), 0);
      check("reset_rd_data", int'(bus.rd_data), 0);
      reset = 1'b0;
      step(1, 7, 0, 0, "idle_no_arm");

      // Rising trigger on a ramp
      set_trigger(0, 1'b0);
      step(0, 0, 1, 0, "t1_arm");
      n = 0;
      for (int i = 0; i < 2000 && phase() != P_DONE; i++) begin
         step(1, n - 128, 0, 0, "t1_status");
         n++;
      end
      check("t1_done", int'(bus.done), 1);
      read_at(0, v);   check("t1_rd0", v, -32);
      read_at(32, v);  check("t1_rd32", v, 0);
      read_at(255, v); check("t1_rd255", v, 223);
      read_window("t1_window");

      // Falling trigger on a descending ramp, sparse strobes
      set_trigger(100, 1'b1);
      step(0, 0, 1, 0, "t2_arm");
      n = 0;
      for (int i = 0; i < 4000 && phase() != P_DONE; i++) begin
         if ($urandom_range(3) != 0) begin
            step(1, 300 - n, 0, 0, "t2_status");
            n++;
         end else begin
            step(0, 0, 0, 0, "t2_status");
         end
      end
      check("t2_done", int'(bus.done), 1);
      read_at(32, v); check("t2_rd32", v, 100);
      read_at(31, v); check("t2_rd31", v, 101);
      read_window("t2_window");

      // Forced trigger; force pulses in PRE must be ignored
      set_trigger(0, 1'b0);
      step(0, 0, 1, 0, "t3_arm");
      for (int i = 0; i < 3; i++) step(1, 5, 0, 1, "t3_pre_force");
      for (int i = 0; i < 200 && phase() == P_PRE; i++) step(1, 5, 0, 0, "t3_pre");
      for (int i = 0; i < 20; i++) step(1, 5, 0, 0, "t3_armed_hold");
      check("t3_armed", int'(bus.armed), 1);
      step(0, 5, 0, 1, "t3_force");
      step(0, 5, 0, 0, "t3_gap");
      step(1, 5, 0, 0, "t3_trig");
      n = 1000;
      for (int i = 0; i < 2000 && phase() != P_DONE; i++) begin
         if ($urandom_range(2) != 0) begin
            step(1, n, 0, 0, "t3_post");
            n++;
         end else begin
            step(0, 0, 0, 0, "t3_post");
         end
      end
      check("t3_done", int'(bus.done), 1);
      read_at(32, v); check("t3_rd32", v, 5);
      read_at(33, v); check("t3_rd33", v, 1000);
      read_window("t3_window");

      // Long ARMED hold across pointer wrap, with ignored arm pulses
      set_trigger(0, 1'b0);
      step(0, 0, 1, 0, "t4_arm");
      for (int i = 0; i < 200 && phase() == P_PRE; i++)
         step(1, -int'($urandom_range(2000, 1)), 0, 0, "t4_pre");
      n = 0;
      for (int i = 0; i < 3000 && n < 1000; i++) begin
         if ($urandom_range(3) != 0) begin
            step(1, -int'($urandom_range(2000, 1)), (n == 500), 0, "t4_armed");
            n++;
         end else begin
            step(0, 0, 0, 0, "t4_armed");
         end
      end
      step(1, 700, 0, 0, "t4_trig");
      for (int i = 0; i < 2000 && phase() != P_DONE; i++)
         step($urandom_range(3) != 0, to_s($urandom), ($urandom_range(15) == 0), 0, "t4_post");
      check("t4_done", int'(bus.done), 1);
      read_window("t4_window");

      // Re-arm from DONE, then asynchronous reset mid-POST
      step(0, 0, 1, 0, "t6_rearm");
      check("t6_busy", int'(bus.busy), 1);
      for (int i = 0; i < 200 && phase() == P_PRE; i++) step(1, -1, 0, 0, "t6_pre");
      step(1, 0, 0, 0, "t6_trig");
      for (int i = 0; i < 20; i++) step(1, i, 0, 0, "t6_post");
      #2;
      reset = 1'b1;
      #1;
      m_active = 1'b0;
      check("t6_reset_status", int'({bus.busy, bus.armed, bus.done}), 0);
      check("t6_reset_rd_data", int'(bus.rd_data), 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int i = 0; i < 10; i++) step(1, to_s($urandom), 0, 1, "t6_idle");

      // Randomized captures: random level, slope, samples, strobes, force and arm pulses
      for (int it = 0; it < 4; it++) begin
         set_trigger(to_s($urandom), bit'($urandom_range(1)));
         step(0, 0, 1, 0, "rand_arm");
         for (int i = 0; i < 4000 && phase() != P_DONE; i++)
            step($urandom_range(3) != 0, to_s($urandom), ($urandom_range(49) == 0),
                 ($urandom_range(49) == 0), "rand_status");
         check("rand_done", int'(bus.done), 1);
         if (phase() == P_DONE) read_window("rand_window");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/signal_capture.md
# signal_capture

Triggered sample-capture buffer that sits directly downstream of the DDS modulation stage. It records the 12-bit signed `signal_out` stream on each DDS sample strobe into a circular RAM. Capture begins with a configurable pre-trigger history and finishes on a level crossing or a forced trigger. The stored window is then held for random-access readout by the display/scope logic until the block is re-armed.

## Interface
Parameters:
- `DATA_W`, 12: sample width, two's complement.
- `DEPTH_LOG2`, 8: buffer holds DEPTH = 2^DEPTH_LOG2 samples.
- `PRETRIG`, 32: samples kept before the trigger sample. Legal range 1 ≤ PRETRIG ≤ DEPTH-1.

Ports (direction, width, meaning):
- `clk`, in, 1: single clock. All logic is on its rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `sample_en`, in, 1: one-cycle strobe. The same strobe that advances the DDS.
- `sample_in`, in, DATA_W: signed sample from the DDS output.
- `arm`, in, 1: pulse that starts a capture.
- `force_trig`, in, 1: pulse that forces a trigger while armed.
- `trig_level`, in, DATA_W: signed trigger threshold.
- `trig_slope`, in, 1: 0 selects a rising crossing, 1 selects a falling crossing.
- `rd_addr`, in, DEPTH_LOG2: logical read index. 0 is the oldest sample; PRETRIG is the trigger sample.
- `rd_data`, out, DATA_W: registered read data.
- `busy`, out, 1: high in PRE, ARMED or POST.
- `armed`, out, 1: high in ARMED.
- `done`, out, 1: high in DONE.

## Operation
- **States:** IDLE, PRE, ARMED, POST, DONE.
- **Accepted sample:** a cycle with `sample_en`=1 while in PRE, ARMED or POST. Each accepted sample is written to `mem[wp]`, then `wp` increments modulo DEPTH (wraps from DEPTH-1 to 0). `prev` is updated to the accepted sample.
- **IDLE → PRE, DONE → PRE:** on `arm`. This clears `wp`, `cnt` and `force_pend`. `arm` in PRE, ARMED or POST is ignored.
- **PRE:** counts accepted samples. After the PRETRIG-th accepted sample, go to ARMED.
- **ARMED:** each accepted sample is a trigger when any of the following holds:
  - rising (`trig_slope`=0): `prev < trig_level` and `sample_in >= trig_level`, signed compare;
  - falling (`trig_slope`=1): `prev > trig_level` and `sample_in <= trig_level`, signed compare;
  - `force_pend`=1.
- **On a trigger:**
  - the trigger sample is written at address `wp`;
  - `start = (wp - PRETRIG) mod DEPTH` is latched;
  - `cnt` is set to DEPTH-PRETRIG-1;
  - `force_pend` is cleared;
  - go to POST, or directly to DONE if DEPTH-PRETRIG-1 = 0.
- **force_trig:** sets `force_pend` only while in ARMED. It is ignored in all other states. If `force_trig` and an accepted sample occur in the same cycle, that sample is the trigger.
- **POST:** each accepted sample decrements `cnt`. The accepted sample that takes `cnt` to 0 moves the block to DONE.
- **DONE:** no writes occur. Contents hold until the next `arm`.
- **Readout:** `rd_data <= mem[(start + rd_addr) mod DEPTH]`. Reads are permitted in every state, but are only defined in DONE.
- **Arithmetic:** signed compares use DATA_W bits. The level equal to the most negative or most positive value needs no special case.
- **Reset (asynchronous):**
  - state = IDLE;
  - `wp`, `cnt`, `start`, `prev`, `force_pend` = 0;
  - `rd_data` = 0;
  - `busy`, `armed`, `done` = 0;
  - RAM contents are not reset.
- **Reset mid-capture:** the capture is abandoned. A new `arm` is required.

## Timing
- `busy`, `armed` and `done` are decoded from the registered state. They change in the cycle after the causing edge.
- `arm` sampled at edge N → `busy`=1 after edge N.
- The last POST sample accepted at edge N → `done`=1 and `busy`=0 after edge N.
- Read latency is 1 cycle: `rd_addr` presented before edge N gives `rd_data` valid after edge N. `rd_addr` may change every cycle.
- `sample_en` may be asserted every cycle or sparsely. Cycles without `sample_en` cause no state change, except for `arm` and `force_trig` handling.
- The RAM has one write port and one read port. There are no read-during-write requirements, because reads matter only in DONE.

## Test plan
1. **Rising trigger on a ramp.**
   - Setup: defaults, `trig_level`=0, `trig_slope`=0.
   - Stimulus: after `arm`, apply `sample_in` = n-128 on every strobe, for n = 0, 1, …
   - Required response: trigger at n=128; `done` rises after the sample with n=351 is accepted; reads give rd[0]=-32, rd[32]=0, rd[255]=223.
2. **Falling trigger on a descending ramp.**
   - Setup: `trig_slope`=1, `trig_level`=100.
   - Stimulus: descending ramp 300, 299, …
   - Required response: rd[32]=100 and rd[31]=101.
3. **Forced trigger.**
   - Stimulus: constant `sample_in`=5 with `trig_level`=0, so no crossing occurs. Pulse `force_trig` in ARMED; the next accepted sample is 5.
   - Required response: it becomes rd[32]; `done` follows after 223 more accepted samples. A `force_trig` pulse in PRE must have no effect.
4. **Wrap-around.**
   - Stimulus: hold ARMED for 1000 samples without a crossing, then cross.
   - Required response: the readout is contiguous, and the oldest-to-newest order is correct across the `wp` wrap.
5. **Ignored arm.**
   - Stimulus: pulse `arm` during ARMED and during POST.
   - Required response: no restart.
6. **Re-arm and reset.**
   - Stimulus: pulse `arm` in DONE.
   - Required response: `busy`=1 next cycle.
   - Stimulus: assert asynchronous `reset` mid-POST, between clock edges.
   - Required response: `busy`, `done` and `rd_data` go to 0 immediately, and the block stays in IDLE until `arm`.
